fpu_mult_responder: RTL and testbench
=====================================

// Module: fpu_mult_responder
// PURPOSE
// Iterative single-precision (IEEE-754 binary32) multiplier that answers the beg_FSM/rst_FSM/ready_flag
// operation handshake used by the FPU operand drivers. It latches Data_MX/Data_MY on a beg_FSM pulse,
// runs a 24-step shift-add mantissa multiply, normalises, rounds per round_mode, then holds the result
// with ready_flag high until rst_FSM. It is a drop-in responder for the 50-cycle operand-driver loop.
// PARAMETERS
// EW   8    exponent width (fixed for binary32)
// SW   23   stored significand width (fixed for binary32)
// BIAS 127  exponent bias
// PORTS
// clk            in   1   clock; all state changes on rising edge
// rst            in   1   asynchronous, active-low reset
// beg_FSM        in   1   start pulse; sampled only in IDLE
// rst_FSM        in   1   synchronous operation clear / acknowledge of result
// Data_MX        in   32  operand X, binary32
// Data_MY        in   32  operand Y, binary32
// round_mode     in   2   00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
// overflow_flag  out  1   result exponent overflowed (registered, valid with ready_flag)
// underflow_flag out  1   result exponent underflowed (registered, valid with ready_flag)
// ready_flag     out  1   result valid; level, held until rst_FSM or rst
// F_ieee_result  out  32  binary32 product
// BEHAVIOUR
// - rst low (any time, incl. mid-operation): state IDLE, all outputs 0, step counter 0, operands cleared.
// - FSM: IDLE -> LOAD -> MULT -> NORM -> ROUND -> DONE. rst_FSM=1 in any state: IDLE on next edge,
//   ready_flag/flags/F_ieee_result cleared. rst_FSM has priority over beg_FSM at the same edge.
// - IDLE: beg_FSM=1 latches Data_MX, Data_MY, round_mode -> LOAD. Later input changes are ignored.
// - LOAD: unpack sign s=X[31]^Y[31], exponents, mantissas with hidden 1. Shortcuts direct to DONE:
//   either exp==0 (zero or subnormal, flushed) -> {s,31'b0}, no flags; else either exp==8'hFF ->
//   {s,8'hFF,23'b0}, overflow_flag=1. The zero check has priority. Otherwise -> MULT.
// - MULT: 24 iterations, one multiplier bit per cycle, 48-bit accumulator P; counter 0..23 -> NORM.
// - NORM: E = Ex+Ey-127 (10-bit signed). If P[47]=1, take M=P[46:24], G=P[23], S=|P[22:0], E=E+1;
//   else M=P[45:23], G=P[22], S=|P[21:0].
// - ROUND: inc = RNE: G&(S|M[0]); RZ: 0; +inf: ~s&(G|S); -inf: s&(G|S). If M+inc carries out,
//   M=0 and E=E+1. Then E>=255 -> {s,8'hFF,0}, overflow_flag=1; E<=0 -> {s,31'b0},
//   underflow_flag=1; else {s,E[7:0],M}. -> DONE.
// - DONE: ready_flag=1, outputs stable; beg_FSM ignored; stays until rst_FSM.
// - Latency (edge N samples beg_FSM=1): normal path ready_flag high after edge N+27; shortcut after N+2.
// - ready_flag never high outside DONE; at most one result per beg_FSM.
// TESTING
// 1) X=3F800000,Y=3F800000,mode 00 -> F=3F800000, flags 0, ready after 27 edges past beg sample.
// 2) X=40400000,Y=40A00000 (3*5) -> F=41700000; X=C0400000 -> F=C1700000.
// 3) X=3F800001,Y=3F800001: mode 00 -> 3F800002, 01 -> 3F800002, 10 -> 3F800003, 11 -> 3F800002.
// 4) X=7F000000,Y=7F000000 -> F=7F800000, overflow_flag=1; X=00800000,Y=00800000 -> F=00000000,
//    underflow_flag=1; X=80000000,Y=40000000 -> F=80000000 in 2 edges, flags 0.
// 5) rst_FSM at MULT step 10 -> IDLE next edge, ready_flag never rises; new beg_FSM gives correct result.
// 6) rst low in ROUND -> all outputs 0 immediately; beg_FSM while in DONE ignored (result unchanged).

Source files
------------

// File: rtl/fpu_mult_responder.sv
// fpu_mult_responder: iterative binary32 multiplier answering the
// beg_FSM / rst_FSM / ready_flag operation handshake. Operands are latched
// on a start pulse, the significands are multiplied with a 24-step shift-add,
// then the product is normalised, rounded, packed and held until acknowledged.
module fpu_mult_responder #(
  parameter int EW   = 8,
  parameter int SW   = 23,
  parameter int BIAS = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beg_FSM,
  input  logic                 rst_FSM,
  input  logic [EW+SW:0]       Data_MX,
  input  logic [EW+SW:0]       Data_MY,
  input  logic [1:0]           round_mode,
  output logic                 overflow_flag,
  output logic                 underflow_flag,
  output logic                 ready_flag,
  output logic [EW+SW:0]       F_ieee_result
);

  localparam int FW = EW + SW + 1;   // full word width
  localparam int MW = SW + 1;        // significand with hidden one
  localparam int PW = 2 * MW;        // product width
  localparam int XW = EW + 2;        // signed working exponent width
  localparam int CW = $clog2(MW);    // step counter width

  localparam logic signed [XW-1:0] C_BIAS = XW'(BIAS);
  localparam logic signed [XW-1:0] C_EMAX = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] C_ONE  = XW'(1);
  localparam logic signed [XW-1:0] C_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MULT, S_NORM, S_ROUND, S_DONE
  } state_t;

  // Round-up decision from guard/sticky/lsb and the selected direction.
  function automatic logic f_round_inc(input logic [1:0] mode, input logic s,
                                       input logic g, input logic st, input logic lsb);
    case (mode)
      2'b00:   return g & (st | lsb);
      2'b01:   return 1'b0;
      2'b10:   return ~s & (g | st);
      default: return s & (g | st);
    endcase
  endfunction

  // Saturating pack: returns {overflow, underflow, word}.
  function automatic logic [FW+1:0] f_pack(input logic s, input logic signed [XW-1:0] e,
                                           input logic [SW-1:0] m);
    if (e >= C_EMAX)      return {2'b10, s, {EW{1'b1}}, {SW{1'b0}}};
    else if (e <= C_ZERO) return {2'b01, s, {(FW-1){1'b0}}};
    else                  return {2'b00, s, e[EW-1:0], m};
  endfunction

  state_t                 r_state;
  logic [FW-1:0]          r_x, r_y;
  logic [1:0]             r_mode;
  logic                   r_sign;
  logic [MW-1:0]          r_mcand, r_mplier;
  logic [PW-1:0]          r_p;
  logic [CW-1:0]          r_cnt;
  logic signed [XW-1:0]   r_exp;
  logic [SW-1:0]          r_m;
  logic                   r_g, r_st;
  logic                   r_special;
  logic [FW+1:0]          r_spec_res;
  logic                   r_ready, r_ov, r_un;
  logic [FW-1:0]          r_f;

  logic [EW-1:0]          w_ex, w_ey;
  logic                   w_sign;
  logic signed [XW-1:0]   w_exp_sum;
  logic                   w_inc;
  logic                   w_carry;
  logic [SW-1:0]          w_m_rnd;
  logic signed [XW-1:0]   w_e_rnd;
  logic [FW+1:0]          w_packed;

  assign w_ex      = r_x[FW-2 -: EW];
  assign w_ey      = r_y[FW-2 -: EW];
  assign w_sign    = r_x[FW-1] ^ r_y[FW-1];
  assign w_exp_sum = $signed({2'b00, w_ex}) + $signed({2'b00, w_ey}) - C_BIAS;

  assign w_inc              = f_round_inc(r_mode, r_sign, r_g, r_st, r_m[0]);
  assign {w_carry, w_m_rnd} = {1'b0, r_m} + {{SW{1'b0}}, w_inc};
  assign w_e_rnd            = r_exp + (w_carry ? C_ONE : C_ZERO);
  assign w_packed           = f_pack(r_sign, w_e_rnd, w_m_rnd);

  assign ready_flag     = r_ready;
  assign overflow_flag  = r_ov;
  assign underflow_flag = r_un;
  assign F_ieee_result  = r_f;

  // Operation FSM: capture, unpack, shift-add multiply, normalise, round, hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_mode     <= '0;
      r_sign     <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_p        <= '0;
      r_cnt      <= '0;
      r_exp      <= '0;
      r_m        <= '0;
      r_g        <= 1'b0;
      r_st       <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_ready    <= 1'b0;
      r_ov       <= 1'b0;
      r_un       <= 1'b0;
      r_f        <= '0;
    end else if (rst_FSM) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_ov    <= 1'b0;
      r_un    <= 1'b0;
      r_f     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (beg_FSM) begin
            r_x     <= Data_MX;
            r_y     <= Data_MY;
            r_mode  <= round_mode;
            r_state <= S_LOAD;
          end
        end
        // Unpack; zero/subnormal and inf/NaN operands skip the datapath but
        // still commit through ROUND so every result lands the same way.
        S_LOAD: begin
          r_sign   <= w_sign;
          r_mcand  <= {1'b1, r_x[SW-1:0]};
          r_mplier <= {1'b1, r_y[SW-1:0]};
          r_p      <= '0;
          r_cnt    <= '0;
          r_exp    <= w_exp_sum;
          if (w_ex == '0 || w_ey == '0) begin
            r_special  <= 1'b1;
            r_spec_res <= {2'b00, w_sign, {(FW-1){1'b0}}};
            r_state    <= S_ROUND;
          end else if (w_ex == '1 || w_ey == '1) begin
            r_special  <= 1'b1;
            r_spec_res <= {2'b10, w_sign, {EW{1'b1}}, {SW{1'b0}}};
            r_state    <= S_ROUND;
          end else begin
            r_special <= 1'b0;
            r_state   <= S_MULT;
          end
        end
        S_MULT: begin
          if (r_mplier[r_cnt])
            r_p <= r_p + ({{MW{1'b0}}, r_mcand} << r_cnt);
          if (r_cnt == CW'(MW - 1)) r_state <= S_NORM;
          else                      r_cnt   <= r_cnt + 1'b1;
        end
        S_NORM: begin
          if (r_p[PW-1]) begin
            r_m   <= r_p[PW-2 -: SW];
            r_g   <= r_p[PW-2-SW];
            r_st  <= |r_p[PW-3-SW:0];
            r_exp <= r_exp + C_ONE;
          end else begin
            r_m  <= r_p[PW-3 -: SW];
            r_g  <= r_p[PW-3-SW];
            r_st <= |r_p[PW-4-SW:0];
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          if (r_special) {r_ov, r_un, r_f} <= r_spec_res;
          else           {r_ov, r_un, r_f} <= w_packed;
          r_ready <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mult_responder.sv
// Directed bench for fpu_mult_responder: a per-cycle compare process checks
// every output against a behavioural expectation, plus hand-computed values.
module tb_fpu_mult_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        beg_FSM = 1'b0;
  logic        rst_FSM = 1'b0;
  logic [31:0] Data_MX = '0;
  logic [31:0] Data_MY = '0;
  logic [1:0]  round_mode = '0;
  logic        overflow_flag, underflow_flag, ready_flag;
  logic [31:0] F_ieee_result;

  fpu_mult_responder dut (
    .clk(clk), .rst(rst), .beg_FSM(beg_FSM), .rst_FSM(rst_FSM),
    .Data_MX(Data_MX), .Data_MY(Data_MY), .round_mode(round_mode),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
    .ready_flag(ready_flag), .F_ieee_result(F_ieee_result)
  );

  always #5 clk = ~clk;

  // expectations written by stimulus only
  logic        exp_ready = 1'b0;
  logic [33:0] exp_res   = '0;
  logic [33:0] hand_res  = '0;
  int          hand_seq  = 0;
  string       hand_name = "";
  logic        stop_cmp  = 1'b0;

  // counters written by the compare process only
  int checks = 0;
  int failures = 0;
  int last_seq = 0;

  // Behavioural product: integer significand product, round by remainder vs half.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic [1:0] md, output logic [33:0] res,
                                output bit special);
    logic s;
    int ex, ey, e, sh;
    longint unsigned p, q, rem, half;
    bit up;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    special = 1'b1;
    if (ex == 0 || ey == 0) res = {2'b00, s, 31'b0};
    else if (ex == 255 || ey == 255) res = {2'b10, s, 8'hFF, 23'b0};
    else begin
      special = 1'b0;
      p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e = ex + ey - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
      else sh = 23;
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      case (md)
        2'd0:    up = (rem > half) || (rem == half && q[0]);
        2'd1:    up = 1'b0;
        2'd2:    up = !s && rem != 0;
        default: up = s && rem != 0;
      endcase
      q = q + longint'(up);
      if (q >= (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
      if (e >= 255)    res = {2'b10, s, 8'hFF, 23'b0};
      else if (e <= 0) res = {2'b01, s, 31'b0};
      else             res = {2'b00, s, 8'(e), q[22:0]};
    end
  endfunction

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (!stop_cmp) begin
      checks = checks + 1;
      if (ready_flag !== exp_ready || {overflow_flag, underflow_flag, F_ieee_result} !==
          (exp_ready ? exp_res : 34'd0)) begin
        failures = failures + 1;
        $display("FAIL cycle_out t=%0t got rdy=%b ov=%b un=%b F=%h want rdy=%b res=%h",
                 $time, ready_flag, overflow_flag, underflow_flag, F_ieee_result,
                 exp_ready, exp_ready ? exp_res : 34'd0);
      end
      if (hand_seq != last_seq) begin
        last_seq = hand_seq;
        checks = checks + 1;
        if ({overflow_flag, underflow_flag, F_ieee_result} !== hand_res) begin
          failures = failures + 1;
          $display("FAIL %s got ov=%b un=%b F=%h want %h", hand_name,
                   overflow_flag, underflow_flag, F_ieee_result, hand_res);
        end
      end
    end
  end

  task automatic hand(input string nm, input logic [33:0] v);
    hand_name = nm;
    hand_res  = v;
    hand_seq  = hand_seq + 1;
  endtask

  // Issue one operation and raise the expectation exactly when the result is due.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] md,
                       input bit use_hand, input string nm, input logic [33:0] hv);
    logic [33:0] r;
    bit sp;
    model(x, y, md, r, sp);
    @(negedge clk);
    Data_MX = x; Data_MY = y; round_mode = md; beg_FSM = 1'b1;
    @(posedge clk); #1;
    beg_FSM = 1'b0; Data_MX = 32'hDEADBEEF; Data_MY = 32'h12345678; round_mode = ~md;
    repeat (sp ? 2 : 27) @(posedge clk);
    #1;
    exp_res   = r;
    exp_ready = 1'b1;
    if (use_hand) hand(nm, hv);
  endtask

  task automatic ack();
    @(negedge clk);
    rst_FSM = 1'b1;
    @(posedge clk); #1;
    rst_FSM   = 1'b0;
    exp_ready = 1'b0;
    exp_res   = '0;
  endtask

  task automatic start_only(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    Data_MX = x; Data_MY = y; round_mode = 2'b00; beg_FSM = 1'b1;
    @(posedge clk); #1;
    beg_FSM = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    hand("reset_state", 34'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(32'h3F800000, 32'h3F800000, 2'b00, 1, "one_x_one", {2'b00, 32'h3F800000}); ack();
    do_op(32'h40400000, 32'h40A00000, 2'b00, 1, "three_x_five", {2'b00, 32'h41700000}); ack();
    do_op(32'hC0400000, 32'h40A00000, 2'b00, 1, "neg_three_x_five", {2'b00, 32'hC1700000}); ack();
    do_op(32'h3F800001, 32'h3F800001, 2'b00, 1, "rnd_nearest", {2'b00, 32'h3F800002}); ack();
    do_op(32'h3F800001, 32'h3F800001, 2'b01, 1, "rnd_zero", {2'b00, 32'h3F800002}); ack();
    do_op(32'h3F800001, 32'h3F800001, 2'b10, 1, "rnd_pinf", {2'b00, 32'h3F800003}); ack();
    do_op(32'h3F800001, 32'h3F800001, 2'b11, 1, "rnd_ninf", {2'b00, 32'h3F800002}); ack();
    do_op(32'h7F000000, 32'h7F000000, 2'b00, 1, "overflow", {2'b10, 32'h7F800000}); ack();
    do_op(32'h00800000, 32'h00800000, 2'b00, 1, "underflow", {2'b01, 32'h00000000}); ack();
    do_op(32'h80000000, 32'h40000000, 2'b00, 1, "zero_short", {2'b00, 32'h80000000}); ack();
    do_op(32'h7F800000, 32'hBF800000, 2'b00, 1, "inf_short", {2'b10, 32'hFF800000}); ack();
    do_op(32'h00000000, 32'h7F800000, 2'b00, 1, "zero_prio", {2'b00, 32'h00000000}); ack();
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b10, 0, "", '0); ack();
    do_op(32'hBFFFFFFF, 32'h3FFFFFFF, 2'b11, 0, "", '0); ack();

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      do_op(a, b, 2'(i), 0, "", '0);
      ack();
    end

    // abort in MULT step 10, then a fresh operation
    start_only(32'h40400000, 32'h40A00000);
    repeat (11) @(posedge clk);
    @(negedge clk); rst_FSM = 1'b1;
    @(posedge clk); #1; rst_FSM = 1'b0;
    repeat (30) @(posedge clk);
    do_op(32'h40400000, 32'h40A00000, 2'b00, 1, "after_abort", {2'b00, 32'h41700000});

    // start pulse while holding a result is ignored
    @(negedge clk);
    Data_MX = 32'h40000000; Data_MY = 32'h40000000; beg_FSM = 1'b1;
    @(posedge clk); #1; beg_FSM = 1'b0;
    repeat (30) @(posedge clk);
    #1 hand("done_hold", {2'b00, 32'h41700000});

    // acknowledge beats a simultaneous start
    @(negedge clk);
    rst_FSM = 1'b1; beg_FSM = 1'b1;
    @(posedge clk); #1;
    rst_FSM = 1'b0; beg_FSM = 1'b0; exp_ready = 1'b0; exp_res = '0;
    repeat (35) @(posedge clk);

    // asynchronous reset while in ROUND
    start_only(32'h40400000, 32'h40A00000);
    repeat (26) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (35) @(posedge clk);

    // asynchronous reset while holding a result clears outputs before the next edge
    do_op(32'h40400000, 32'h40A00000, 2'b00, 0, "", '0);
    @(posedge clk); #2;
    rst = 1'b0; exp_ready = 1'b0; exp_res = '0;
    hand("async_clear", 34'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    do_op(32'h3F800000, 32'h3F800000, 2'b00, 1, "after_reset", {2'b00, 32'h3F800000}); ack();

    @(negedge clk); #1;
    stop_cmp = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
